mac_array: RTL and testbench

MAC_ARRAY -- requirements
Module: mac_array

---
 rtl/snn_pkg.sv | 20 ++
 rtl/fp32_adder.sv | 89 ++++++++
 rtl/mac_array.sv | 145 ++++++++++++++
 tb/tb_mac_array.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the synapse MAC array: FSM encoding, FP32 field layout
// and constants, and the synapse-count ceiling.
package snn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    localparam int          FP_W       = 32;
    localparam int          FP_EXP_W   = 8;
    localparam int          FP_MAN_W   = 23;
    localparam int          FP_BIAS    = 127;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;

    localparam int N_SYN_MAX = 64;

endpackage

// File: rtl/fp32_adder.sv
// Combinational FP32 adder: round toward zero, denormals flushed to signed zero,
// any Inf/NaN operand yields the canonical quiet NaN.
module fp32_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    import snn_pkg::*;

    localparam int EXT_W = 26;
    localparam int MX_W  = 24 + EXT_W;

    logic                sa, sb, a_zero, b_zero, swap, s_big;
    logic [7:0]          ea, eb, e_big, e_sml, shamt;
    logic [22:0]         fa, fb;
    logic [23:0]         m_big, m_sml;
    logic [MX_W-1:0]     big_x, sml_x, aligned;
    logic [MX_W:0]       raw;
    logic [5:0]          lead;
    logic signed [9:0]   e_res;
    logic [22:0]         frac;

    assign sa     = a[31];
    assign sb     = b[31];
    assign ea     = a[30:23];
    assign eb     = b[30:23];
    assign fa     = a[22:0];
    assign fb     = b[22:0];
    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);

    assign swap  = {eb, fb} > {ea, fa};
    assign s_big = swap ? sb : sa;
    assign e_big = swap ? eb : ea;
    assign e_sml = swap ? ea : eb;
    assign m_big = {1'b1, (swap ? fb : fa)};
    assign m_sml = {1'b1, (swap ? fa : fb)};
    assign shamt = e_big - e_sml;
    assign big_x = {m_big, {EXT_W{1'b0}}};
    assign sml_x = {m_sml, {EXT_W{1'b0}}};

    // Shifted-out bits are jammed into the LSB so truncation stays exact under subtraction
    always_comb begin
        if (shamt >= 8'd50) begin
            aligned = {{(MX_W-1){1'b0}}, 1'b1};
        end else begin
            aligned = sml_x >> shamt;
            if ((aligned << shamt) != sml_x) begin
                aligned[0] = 1'b1;
            end
        end
    end

    assign raw = (sa == sb) ? ({1'b0, big_x} + {1'b0, aligned})
                            : ({1'b0, big_x} - {1'b0, aligned});

    always_comb begin
        lead = '0;
        for (int i = 0; i <= MX_W; i++) begin
            if (raw[i]) begin
                lead = 6'(i);
            end
        end
    end

    assign e_res = $signed({2'b00, e_big}) + $signed({4'b0000, lead}) - 10'sd49;
    assign frac  = 23'((raw << (6'd50 - lead)) >> 27);

    always_comb begin
        if (ea == FP_EXP_MAX || eb == FP_EXP_MAX) begin
            sum = FP_QNAN;
        end else if (a_zero && b_zero) begin
            sum = {sa & sb, 31'd0};
        end else if (a_zero) begin
            sum = b;
        end else if (b_zero) begin
            sum = a;
        end else if (raw == '0) begin
            sum = 32'd0;
        end else if (e_res <= 10'sd0) begin
            sum = {s_big, 31'd0};
        end else if (e_res >= 10'sd255) begin
            sum = {s_big, 8'hFE, 23'h7FFFFF};
        end else begin
            sum = {s_big, e_res[7:0], frac};
        end
    end

endmodule

// File: rtl/mac_array.sv
// Event-driven synapse MAC: each accepted spike scans the synapse table one entry
// per cycle, adding matching FP32 weights; step_end emits and clears the sum.
module mac_array #(
    parameter int N_SYN  = 5,
    parameter int ADDR_W = 12,
    parameter int W_W    = 32,
    localparam int IDX_W = (N_SYN > 1) ? $clog2(N_SYN) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_src,
    input  logic [W_W-1:0]    cfg_weight,
    input  logic              spike_valid,
    output logic              spike_ready,
    input  logic [ADDR_W-1:0] spike_src,
    input  logic              step_end,
    input  logic              clear,
    output logic [W_W-1:0]    result,
    output logic              result_valid,
    output logic              busy
);
    import snn_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SYN - 1);
    localparam logic [IDX_W:0]   N_SYN_L  = (IDX_W + 1)'(N_SYN);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    scan_idx_q, scan_idx_d;
    logic [ADDR_W-1:0]   spike_src_q, spike_src_d;
    logic [W_W-1:0]      acc_q, acc_d;
    logic [W_W-1:0]      result_q, result_d;
    logic                result_valid_q, result_valid_d;
    logic                pending_q, pending_d;
    logic [N_SYN-1:0]    valid_q, valid_d;
    logic [ADDR_W-1:0]   src_q [N_SYN];
    logic [ADDR_W-1:0]   src_d [N_SYN];
    logic [W_W-1:0]      weight_q [N_SYN];
    logic [W_W-1:0]      weight_d [N_SYN];

    logic                cfg_hit, match, step_req, pend_next;
    logic [W_W-1:0]      add_sum;

    assign busy         = (state_q != ST_IDLE) || pending_q;
    assign spike_ready  = (state_q == ST_IDLE) && !RESET;
    assign result       = result_q;
    assign result_valid = result_valid_q;

    assign cfg_hit   = cfg_we && !busy && ({1'b0, cfg_idx} < N_SYN_L);
    assign match     = (state_q == ST_SCAN) && valid_q[scan_idx_q]
                       && (src_q[scan_idx_q] == spike_src_q);
    // A clear in the same cycle swallows the timestep end
    assign step_req  = step_end && !clear;
    assign pend_next = (pending_q || step_end) && !clear;

    fp32_adder u_fp32_adder (
        .a   (acc_q),
        .b   (weight_q[scan_idx_q]),
        .sum (add_sum)
    );

    always_comb begin
        state_d        = state_q;
        scan_idx_d     = scan_idx_q;
        spike_src_d    = spike_src_q;
        acc_d          = acc_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        pending_d      = pending_q;
        valid_d        = valid_q;
        src_d          = src_q;
        weight_d       = weight_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_hit) begin
                    valid_d[cfg_idx]  = 1'b1;
                    src_d[cfg_idx]    = cfg_src;
                    weight_d[cfg_idx] = cfg_weight;
                end
                // A spike wins the cycle; a coincident step_end waits for the scan
                if (spike_valid) begin
                    state_d     = ST_SCAN;
                    scan_idx_d  = '0;
                    spike_src_d = spike_src;
                    pending_d   = step_req;
                end else if (step_req) begin
                    state_d = ST_EMIT;
                end
            end
            ST_SCAN: begin
                if (match) begin
                    acc_d = add_sum;
                end
                if (scan_idx_q == LAST_IDX) begin
                    state_d   = pend_next ? ST_EMIT : ST_IDLE;
                    pending_d = 1'b0;
                end else begin
                    scan_idx_d = scan_idx_q + 1'b1;
                    pending_d  = pend_next;
                end
            end
            ST_EMIT: begin
                result_d       = acc_q;
                result_valid_d = 1'b1;
                acc_d          = '0;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (clear) begin
            acc_d     = '0;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q        <= ST_IDLE;
            scan_idx_q     <= '0;
            acc_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            pending_q      <= 1'b0;
            valid_q        <= '0;
        end else begin
            state_q        <= state_d;
            scan_idx_q     <= scan_idx_d;
            acc_q          <= acc_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            pending_q      <= pending_d;
            valid_q        <= valid_d;
        end
    end

    always_ff @(posedge CLK) begin
        spike_src_q <= spike_src_d;
        src_q       <= src_d;
        weight_q    <= weight_d;
    end

endmodule

// File: tb/tb_mac_array.sv
// Self-checking bench for mac_array: directed scenarios plus randomized integer-valued
// weights compared against an arithmetic model of the membrane sum.
module tb_mac_array;

    localparam int N_SYN  = 5;
    localparam int ADDR_W = 12;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              cfg_we = 1'b0;
    logic [2:0]        cfg_idx = '0;
    logic [ADDR_W-1:0] cfg_src = '0;
    logic [31:0]       cfg_weight = '0;
    logic              spike_valid = 1'b0;
    logic              spike_ready;
    logic [ADDR_W-1:0] spike_src = '0;
    logic              step_end = 1'b0;
    logic              clear = 1'b0;
    logic [31:0]       result;
    logic              result_valid;
    logic              busy;

    int checks = 0;
    int passes = 0;

    mac_array #(.N_SYN(N_SYN), .ADDR_W(ADDR_W), .W_W(32)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .cfg_we       (cfg_we),
        .cfg_idx      (cfg_idx),
        .cfg_src      (cfg_src),
        .cfg_weight   (cfg_weight),
        .spike_valid  (spike_valid),
        .spike_ready  (spike_ready),
        .spike_src    (spike_src),
        .step_end     (step_end),
        .clear        (clear),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    // Exact FP32 encoding of a small integer (|v| < 2^24)
    function automatic logic [31:0] int_to_fp(input int v);
        int a;
        int msb;
        logic [31:0] m;
        if (v == 0) return 32'd0;
        a = (v < 0) ? -v : v;
        msb = 0;
        for (int i = 0; i < 31; i++) if ((a >> i) != 0) msb = i;
        m = 32'(a) << (23 - msb);
        return {(v < 0), 8'(127 + msb), m[22:0]};
    endfunction

    task automatic apply_reset();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_cfg(input int idx, input int src, input logic [31:0] w);
        cfg_we = 1'b1;
        cfg_idx = 3'(idx);
        cfg_src = ADDR_W'(src);
        cfg_weight = w;
        @(posedge CLK);
        #1 cfg_we = 1'b0;
    endtask

    task automatic do_spike(input int src, output int lat);
        int n = 0;
        while (!spike_ready && n < 50) begin
            @(posedge CLK); #1; n++;
        end
        spike_valid = 1'b1;
        spike_src = ADDR_W'(src);
        @(posedge CLK);
        #1 spike_valid = 1'b0;
        lat = 0;
        while (!spike_ready && lat < 50) begin
            @(posedge CLK); #1; lat++;
        end
        if (lat >= 50) begin
            checks++;
            $display("FAIL spike_timeout: spike_ready still %b after %0d cycles, required 1", spike_ready, lat);
        end
    endtask

    task automatic do_step(input bit with_clear, output logic [31:0] res, output int pulses);
        step_end = 1'b1;
        clear = with_clear;
        @(posedge CLK);
        #1 step_end = 1'b0;
        clear = 1'b0;
        pulses = 0;
        res = result;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK); #1;
            if (result_valid) begin
                if (pulses == 0) res = result;
                pulses++;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (spike_ready !== 1'b0) $display("FAIL reset_ready: got %b need 0", spike_ready); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b need 0", busy); else passes++;
        checks++; if (result !== 32'h0) $display("FAIL reset_result: got %h need 00000000", result); else passes++;
        checks++; if (result_valid !== 1'b0) $display("FAIL reset_rv: got %b need 0", result_valid); else passes++;
        apply_reset();
        checks++; if (spike_ready !== 1'b1) $display("FAIL idle_ready: got %b need 1", spike_ready); else passes++;
    endtask

    task automatic test_basic_sum();
        int lat, pulses;
        logic [31:0] res;
        apply_reset();
        do_cfg(0, 3, 32'h3F800000);
        do_cfg(1, 4, 32'h40000000);
        do_spike(3, lat);
        do_spike(4, lat);
        do_step(1'b0, res, pulses);
        checks++; if (res !== 32'h40400000) $display("FAIL basic_result: got %h need 40400000", res); else passes++;
        checks++; if (pulses !== 1) $display("FAIL basic_pulse: got %0d strobes need 1", pulses); else passes++;
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (result !== 32'h40400000) $display("FAIL result_hold: got %h need 40400000", result); else passes++;
    endtask

    task automatic test_duplicates();
        int lat, pulses;
        logic [31:0] res;
        apply_reset();
        do_cfg(0, 5, 32'h3F800000);
        do_cfg(2, 5, 32'h3F800000);
        do_spike(5, lat);
        do_spike(9, lat);
        do_step(1'b0, res, pulses);
        checks++; if (res !== 32'h40000000) $display("FAIL dup_result: got %h need 40000000", res); else passes++;
        do_spike(9, lat);
        do_step(1'b0, res, pulses);
        checks++; if (res !== 32'h00000000) $display("FAIL nomatch_result: got %h need 00000000", res); else passes++;
    endtask

    task automatic test_latency_pending();
        int lat, pulses, rv_cyc, low_cnt, busy_cnt;
        logic [31:0] res;
        apply_reset();
        do_cfg(0, 7, 32'h40000000);
        do_spike(7, lat);
        checks++; if (lat !== N_SYN) $display("FAIL spike_latency: got %0d cycles need %0d", lat, N_SYN); else passes++;
        spike_valid = 1'b1;
        spike_src = ADDR_W'(7);
        @(posedge CLK);
        #1 spike_valid = 1'b0;
        rv_cyc = -1; low_cnt = 0; busy_cnt = 0; res = '0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge CLK); #1;
            if (i == 1) step_end = 1'b1;
            if (i == 2) step_end = 1'b0;
            if (i <= 5 && !spike_ready) low_cnt++;
            if (i <= 5 && busy) busy_cnt++;
            if (result_valid && rv_cyc < 0) begin rv_cyc = i; res = result; end
        end
        checks++; if (low_cnt !== 5) $display("FAIL pend_ready_low: got %0d low cycles need 5", low_cnt); else passes++;
        checks++; if (busy_cnt !== 5) $display("FAIL pend_busy: got %0d busy cycles need 5", busy_cnt); else passes++;
        checks++; if (rv_cyc !== 6) $display("FAIL pend_rv_cycle: got %0d need 6", rv_cyc); else passes++;
        checks++; if (res !== 32'h40800000) $display("FAIL pend_result: got %h need 40800000", res); else passes++;
        do_step(1'b0, res, pulses);
        checks++; if (res !== 32'h0) $display("FAIL pend_after: got %h need 00000000", res); else passes++;
    endtask

    task automatic test_clear_step();
        int lat, pulses;
        logic [31:0] res;
        apply_reset();
        do_cfg(0, 1, 32'h3F800000);
        do_spike(1, lat);
        do_step(1'b1, res, pulses);
        checks++; if (pulses !== 0) $display("FAIL clear_step_pulses: got %0d need 0", pulses); else passes++;
        do_step(1'b0, res, pulses);
        checks++; if (res !== 32'h0) $display("FAIL clear_result: got %h need 00000000", res); else passes++;
        checks++; if (pulses !== 1) $display("FAIL clear_plain_pulse: got %0d need 1", pulses); else passes++;
    endtask

    task automatic test_reset_mid_scan();
        int lat, pulses;
        logic [31:0] res;
        apply_reset();
        do_cfg(0, 3, 32'h3F800000);
        do_spike(3, lat);
        do_step(1'b0, res, pulses);
        spike_valid = 1'b1;
        spike_src = ADDR_W'(3);
        @(posedge CLK);
        #1 spike_valid = 1'b0;
        @(posedge CLK);
        #2 RESET = 1'b1;
        #1;
        checks++; if (spike_ready !== 1'b0) $display("FAIL mid_rst_ready: got %b need 0", spike_ready); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b need 0", busy); else passes++;
        checks++; if (result !== 32'h0) $display("FAIL mid_rst_result: got %h need 00000000", result); else passes++;
        checks++; if (result_valid !== 1'b0) $display("FAIL mid_rst_rv: got %b need 0", result_valid); else passes++;
        @(posedge CLK);
        #1 RESET = 1'b0;
        @(posedge CLK);
        #1;
        do_spike(3, lat);
        do_step(1'b0, res, pulses);
        checks++; if (res !== 32'h0) $display("FAIL mid_rst_entries: got %h need 00000000", res); else passes++;
    endtask

    task automatic test_special_values();
        int lat, pulses;
        logic [31:0] res;
        apply_reset();
        do_cfg(0, 2, 32'h7F800000);
        do_spike(2, lat);
        do_step(1'b0, res, pulses);
        checks++; if (res !== 32'h7FC00000) $display("FAIL inf_result: got %h need 7FC00000", res); else passes++;
        apply_reset();
        do_cfg(0, 2, 32'h00000001);
        do_spike(2, lat);
        do_step(1'b0, res, pulses);
        checks++; if (res !== 32'h00000000) $display("FAIL denorm_result: got %h need 00000000", res); else passes++;
        apply_reset();
        do_cfg(0, 2, 32'h3F800000);
        do_cfg(1, 2, 32'hA1800000);
        do_spike(2, lat);
        do_step(1'b0, res, pulses);
        checks++; if (res !== 32'h3F7FFFFF) $display("FAIL rz_result: got %h need 3F7FFFFF", res); else passes++;
    endtask

    task automatic test_cfg_guard();
        int lat, pulses;
        logic [31:0] res;
        apply_reset();
        do_cfg(5, 8, 32'h3F800000);
        spike_valid = 1'b1;
        spike_src = ADDR_W'(0);
        @(posedge CLK);
        #1 spike_valid = 1'b0;
        do_cfg(1, 8, 32'h3F800000);
        do_spike(8, lat);
        do_step(1'b0, res, pulses);
        checks++; if (res !== 32'h0) $display("FAIL cfg_guard: got %h need 00000000", res); else passes++;
        do_cfg(1, 8, 32'h3F800000);
        do_spike(8, lat);
        do_step(1'b0, res, pulses);
        checks++; if (res !== 32'h3F800000) $display("FAIL cfg_idle_write: got %h need 3F800000", res); else passes++;
    endtask

    task automatic test_random();
        int m_src[N_SYN];
        int m_w[N_SYN];
        int sum, lat, pulses, nsp, s;
        logic [31:0] res;
        apply_reset();
        for (int r = 0; r < 8; r++) begin
            for (int e = 0; e < N_SYN; e++) begin
                m_src[e] = int'($urandom_range(3));
                m_w[e] = int'($urandom_range(200)) - 100;
                do_cfg(e, m_src[e], int_to_fp(m_w[e]));
            end
            sum = 0;
            nsp = int'($urandom_range(4, 1));
            for (int k = 0; k < nsp; k++) begin
                s = int'($urandom_range(4));
                for (int e = 0; e < N_SYN; e++) if (m_src[e] == s) sum += m_w[e];
                do_spike(s, lat);
            end
            do_step(1'b0, res, pulses);
            checks++;
            if (res !== int_to_fp(sum) || pulses !== 1)
                $display("FAIL random_round%0d: got %h (%0d strobes) need %h (sum %0d, 1 strobe)",
                         r, res, pulses, int_to_fp(sum), sum);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_duplicates();
        test_latency_pending();
        test_clear_step();
        test_reset_mid_scan();
        test_special_values();
        test_cfg_guard();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
